// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - windowed sample capture into an on-chip FIFO with a registered read port
module capture_buffer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [15:0]              length,
  input  logic [DECIM_W-1:0]       decim,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     rd_en,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic [ADDR_W:0]          count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Window control latched at start so host wire changes cannot disturb a capture.
  logic [15:0]              len_r;
  logic [DECIM_W-1:0]       dec_r;
  logic [15:0]              slot_cnt;
  logic [DECIM_W-1:0]       dec_cnt;

  // FIFO storage and pointers; count carries one extra bit so 1024 is representable.
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        rd_ptr;

  // Decoded per-cycle controls.
  logic start_ok;
  logic slot;
  logic last_slot;
  logic fifo_full;
  logic rd_accept;
  logic wr_en;
  logic drop;
  logic done_nxt;
  logic busy_nxt;

  // State register plus the registered busy/done flags that follow it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state decode; abort overrides everything, start is ignored mid-capture.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nxt = (length == 16'd0) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (last_slot) begin
            state_nxt = S_DONE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output/control decode: slot timing, FIFO push/pop qualification and pulse sources.
  always_comb begin
    start_ok  = start && !abort && (state != S_CAPTURE);
    slot      = (state == S_CAPTURE) && !abort && (dec_cnt == '0);
    last_slot = slot && (slot_cnt == (len_r - 16'd1));
    fifo_full = (count == FULL_COUNT);
    // A flush takes priority over a pop in the same cycle; an empty FIFO never pops,
    // even if a write lands in that cycle (no bypass path).
    rd_accept = rd_en && (count != '0) && !start_ok;
    // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
    wr_en     = slot && (!fifo_full || rd_accept);
    drop      = slot && fifo_full && !rd_accept;
    done_nxt  = !abort && ((start_ok && (length == 16'd0)) || last_slot);
    busy_nxt  = (state_nxt == S_CAPTURE);
  end

  // Window bookkeeping: latch controls on start, advance slot and decimation counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_r    <= '0;
      dec_r    <= '0;
      slot_cnt <= '0;
      dec_cnt  <= '0;
    end else if (start_ok) begin
      len_r    <= length;
      dec_r    <= decim;
      slot_cnt <= '0;
      dec_cnt  <= '0;
    end else if (slot) begin
      // Dropped slots still advance the window; it is time-based, not data-based.
      slot_cnt <= slot_cnt + 16'd1;
      dec_cnt  <= dec_r;
    end else if ((state == S_CAPTURE) && (dec_cnt != '0)) begin
      dec_cnt  <= dec_cnt - 1'b1;
    end
  end

  // FIFO pointers and occupancy; start flushes by zeroing both pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set on any dropped slot, cleared only by a new start or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (start_ok) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Sample storage; no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // Registered read port: data and valid appear the cycle after an accepted pop.
  // When full, a simultaneous write to the same address returns the old word here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - directed self-checking bench for capture_buffer
module tb_capture_buffer;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               abort;
  logic [15:0]        length;
  logic [7:0]         decim;
  logic signed [15:0] sample_in;
  logic               rd_en;
  logic signed [15:0] rd_data;
  logic               rd_valid;
  logic [10:0]        count;
  logic               busy;
  logic               done;
  logic               overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  capture_buffer #(.DATA_W(16), .ADDR_W(10), .DECIM_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .length    (length),
    .decim     (decim),
    .sample_in (sample_in),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; sample_in ramps by one per cycle and the pulse inputs self-clear.
  task automatic step();
    @(posedge clk);
    #1;
    sample_in = sample_in + 16'sd1;
    start     = 1'b0;
    abort     = 1'b0;
  endtask

  // Returns the number of steps until done is seen, or -1 if the budget expires.
  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic read_seq(input string tag, input int n, input logic [15:0] first, input int stride);
    logic [15:0] exp;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == n - 1) rd_en = 1'b0;
      exp = first + 16'(i * stride);
      check({tag, "_vld"}, 32'(rd_valid), 32'd1);
      check({tag, "_dat"}, {16'd0, rd_data[15:0]}, {16'd0, exp});
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          got;
    int          seen;
    logic [15:0] s0;
    logic [15:0] last4;

    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    rd_en     = 1'b0;
    length    = 16'd0;
    decim     = 8'd0;
    sample_in = 16'sd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_vld", 32'(rd_valid), 32'd0);
    check("rst_data", {16'd0, rd_data[15:0]}, 32'd0);
    reset_n = 1'b1;
    step();

    // 1: length 8, no decimation, ramp from 100
    sample_in = 16'sd99;
    length    = 16'd8;
    decim     = 8'd0;
    start     = 1'b1;
    step();
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(20, n);
    check("t1_done_lat", n, 32'd8);
    step();
    check("t1_done_once", 32'(done), 32'd0);
    check("t1_count", 32'(count), 32'd8);
    check("t1_busy_end", 32'(busy), 32'd0);
    read_seq("t1_rd", 8, 16'd100, 1);
    step();
    check("t1_vld_idle", 32'(rd_valid), 32'd0);

    // 2: length 4, decimation 2 -> every third cycle
    s0     = sample_in;
    length = 16'd4;
    decim  = 8'd2;
    start  = 1'b1;
    wait_done(30, n);
    check("t2_done_lat", n, 32'd11);
    check("t2_count", 32'(count), 32'd4);
    step();
    check("t2_busy", 32'(busy), 32'd0);
    read_seq("t2_rd", 4, s0 + 16'd1, 3);

    // 3: window longer than FIFO, no reads
    s0     = sample_in;
    length = 16'd1100;
    decim  = 8'd0;
    start  = 1'b1;
    wait_done(1200, n);
    check("t3_done_lat", n, 32'd1101);
    check("t3_count", 32'(count), 32'd1024);
    check("t3_ovf", 32'(overflow), 32'd1);
    read_seq("t3_rd", 1024, s0 + 16'd1, 1);
    check("t3_empty", 32'(count), 32'd0);

    // 4: same window with continuous reads from start
    s0     = sample_in;
    length = 16'd1100;
    start  = 1'b1;
    rd_en  = 1'b1;
    got    = 0;
    for (int i = 0; i < 1400 && got < 1100; i++) begin
      step();
      if (rd_valid === 1'b1) begin
        check("t4_dat", {16'd0, rd_data[15:0]}, {16'd0, s0 + 16'd1 + 16'(got)});
        got++;
      end
    end
    rd_en = 1'b0;
    last4 = s0 + 16'd1100;
    check("t4_got", got, 32'd1100);
    check("t4_ovf", 32'(overflow), 32'd0);
    repeat (3) step();
    check("t4_count", 32'(count), 32'd0);

    // 5: zero-length window, then a read on empty
    length = 16'd0;
    start  = 1'b1;
    step();
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_count", 32'(count), 32'd0);
    step();
    check("t5_done_once", 32'(done), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t5_vld", 32'(rd_valid), 32'd0);
    check("t5_hold", {16'd0, rd_data[15:0]}, {16'd0, last4});

    // 6: async reset mid-capture, fresh capture, then abort mid-window
    length = 16'd20;
    decim  = 8'd0;
    start  = 1'b1;
    repeat (6) step();
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_count_pre", 32'(count), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_vld", 32'(rd_valid), 32'd0);
    check("t6_rst_data", {16'd0, rd_data[15:0]}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s0      = sample_in;
    length  = 16'd3;
    start   = 1'b1;
    wait_done(10, n);
    check("t6_done_lat", n, 32'd4);
    check("t6_count", 32'(count), 32'd3);
    read_seq("t6_rd", 3, s0 + 16'd1, 1);

    s0     = sample_in;
    length = 16'd10;
    decim  = 8'd3;
    start  = 1'b1;
    repeat (6) step();
    check("t6_ab_count_pre", 32'(count), 32'd2);
    abort = 1'b1;
    seen  = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1) seen++;
    end
    check("t6_ab_nodone", seen, 32'd0);
    check("t6_ab_busy", 32'(busy), 32'd0);
    check("t6_ab_count", 32'(count), 32'd2);
    read_seq("t6_ab_rd", 2, s0 + 16'd1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
